tridiag_det_sched: RTL and testbench
====================================

// Module: tridiag_det_sched
// PURPOSE
//  Shares one tridiag_det_algo engine among NREQ requesters using round-robin arbitration.
//  - Muxes the granted requester's a/b/c vectors onto the engine.
//  - Sequences the engine handshake: start, wait for done, capture det, ack, drain.
//  - Returns each result tagged with the requester id.
//  Sits between the accelerator front-end (MMIO/RoCC job slots) and the single engine instance.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  N       16  matrix order; must match the engine (3..16)
//  WIDTH   16  coefficient width; det is 2*WIDTH
//  TIMEOUT 64  WAIT-state cycle limit (used only with TDS_TIMEOUT_EN)
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 asynchronous active-low reset
//  req        in   NREQ              level request, one bit per requester
//  gnt        out  NREQ              one-cycle grant pulse, one-hot
//  a_in       in   NREQ*WIDTH*(N-1)  per-requester a_flat, requester k at slice k
//  b_in       in   NREQ*WIDTH*N      per-requester b_flat
//  c_in       in   NREQ*WIDTH*(N-1)  per-requester c_flat
//  rsp_valid  out  1                 one-cycle result pulse
//  rsp_id     out  $clog2(NREQ)      requester index of the result
//  rsp_det    out  2*WIDTH           signed determinant
//  rsp_err    out  1                 1 = job aborted by timeout
//  busy       out  1                 high in every state except IDLE
//  eng_start  out  1                 engine start
//  eng_ack    out  1                 engine ack
//  eng_done   in   1                 engine done
//  eng_det    in   2*WIDTH           engine det
//  eng_a/b/c  out  as engine         muxed coefficient vectors
//  eng_rst    out  1                 active-high engine reset request; integrator ORs it with ~rst_n
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, rr_ptr=0, sel=0.
//  FSM states:
//  - IDLE: if |req, winner = first set bit at or after rr_ptr (wrapping); sel<=winner; gnt[winner]=1 for 1 cycle -> START.
//  - START: eng_start=1 for exactly 1 cycle -> WAIT.
//  - WAIT: on eng_done=1: rsp_det<=eng_det, rsp_id<=sel -> ACK.
//  - ACK: eng_ack=1 and rsp_valid=1 for 1 cycle -> DRAIN.
//  - DRAIN: hold until eng_done=0; then rr_ptr<=sel+1 (mod NREQ) -> IDLE.
//  Datapath and hold rules:
//  - eng_a/b/c = slice sel of a_in/b_in/c_in, combinationally muxed from registered sel.
//  - sel is stable from START through DRAIN.
//  - Requester holds req and its slice from gnt until rsp_valid with its id; may drop req the cycle after rsp_valid.
//  - Requester k is never granted twice while any other req bit is pending (fairness); at most one job in flight.
//  Timing and widths:
//  - Latency gnt->rsp_valid = 1 + (N-2) engine iterations + 2 (done, ack) cycles; min 3 idle-to-idle gap.
//  - No arithmetic in this block; det passes through unchanged (signed, 2*WIDTH).
//  Boundary cases:
//  - A req dropped before its gnt is simply not served.
//  - A new req arriving while the FSM is not in IDLE waits for IDLE.
//  - Only one requester pending: it is granted regardless of rr_ptr.
//  - rsp_valid never coincides with gnt.
//  - rst_n low mid-job: the job is lost; no rsp.
// CONFIGURATION
//  TDS_TIMEOUT_EN defined:
//  - A counter runs in WAIT.
//  - If TIMEOUT cycles elapse without eng_done: eng_rst=1 for 2 cycles, rsp_valid=1, rsp_err=1, rsp_det=0, rsp_id=sel, then IDLE.
//  - rr_ptr advances as for a normal job.
//  TDS_TIMEOUT_EN undefined: no counter; eng_rst and rsp_err tied 0; WAIT waits indefinitely.
// STRUCTURE
//  tridiag_det_pkg:
//  - state enum (IDLE, START, WAIT, ACK, DRAIN)
//  - id-width function clog2(NREQ)
//  - slice-offset helper constants
//  Sub-module tds_rr_arbiter:
//  - inputs req, rr_ptr; outputs one-hot winner and winner index; purely combinational.
//  Top module: FSM, sel/rr_ptr registers, coefficient mux, result registers, optional timeout.
// TESTING
//  Bench config NREQ=4, N=4, WIDTH=16, real engine instance.
//  1. Req0 only, b={2,2,2,2}, a=c={1,1,1}: gnt[0], then rsp_valid with id=0, det=5, err=0; busy falls after DRAIN.
//  2. req=4'b1111, all slices distinct: grants in order 0,1,2,3; each rsp_id matches the preceding gnt.
//  3. Fairness: req0 held permanently, req2 asserted during req0's job: next grant is 2, not 0.
//  4. Negative values, b={-3,4,-1,2}, a={1,-2,1}, c={2,1,-1}: rsp_det equals a software model (signed).
//  5. rst_n pulsed low in WAIT: all outputs 0 asynchronously; next req0 completes correctly with rr_ptr=0.
//  6. TDS_TIMEOUT_EN, TIMEOUT=8, engine stub never raises done:
//     - eng_rst high 2 cycles at WAIT+8
//     - rsp_err=1, rsp_det=0
//     - next requester served normally

Source files
------------

// File: rtl/tridiag_det_pkg.sv
// Shared types and sizing helpers for the tridiagonal-determinant engine scheduler.
package tridiag_det_pkg;

    // S_TOUT is reachable only when TDS_TIMEOUT_EN is defined.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_DRAIN = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

    localparam int TOUT_CYCLES = 2;

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Per-requester slice widths of the off-diagonal (a/c) and diagonal (b) vectors.
    function automatic int slice_w_off(input int n, input int w);
        return w * (n - 1);
    endfunction

    function automatic int slice_w_diag(input int n, input int w);
        return w * n;
    endfunction

endpackage

// File: rtl/tds_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr_i, wrapping.
module tds_rr_arbiter
    import tridiag_det_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IDW-1:0]  win_idx_o,
    output logic            win_vld_o
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        win_vld_o = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr_i} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!win_vld_o && req_i[cand]) begin
                win_vld_o      = 1'b1;
                win_idx_o      = cand;
                win_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tridiag_det_sched.sv
// Shares one tridiag_det_algo engine among NREQ requesters with round-robin grants.
// Build option TDS_TIMEOUT_EN: abort a job whose engine stays silent for TIMEOUT WAIT cycles.
module tridiag_det_sched
    import tridiag_det_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int N       = 16,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    localparam int IDW    = id_w(NREQ),
    localparam int AW     = slice_w_off(N, WIDTH),
    localparam int BW     = slice_w_diag(N, WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ*AW-1:0]   a_in,
    input  logic [NREQ*BW-1:0]   b_in,
    input  logic [NREQ*AW-1:0]   c_in,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*WIDTH-1:0]   rsp_det,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_start,
    output logic                 eng_ack,
    input  logic                 eng_done,
    input  logic [2*WIDTH-1:0]   eng_det,
    output logic [AW-1:0]        eng_a,
    output logic [BW-1:0]        eng_b,
    output logic [AW-1:0]        eng_c,
    output logic                 eng_rst,
    output state_t               state_dbg
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     sel_q, sel_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_det_q, rsp_det_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDW-1:0]     sel_next;
    logic [NREQ-1:0]    win_oh;
    logic [IDW-1:0]     win_idx;
    logic               win_vld;

`ifdef TDS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;
`endif

    tds_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .win_oh_o (win_oh),
        .win_idx_o(win_idx),
        .win_vld_o(win_vld)
    );

    assign sel_next = (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_id_d  = rsp_id_q;
        rsp_det_d = rsp_det_q;
        gnt_d     = '0;
`ifdef TDS_TIMEOUT_EN
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    sel_d   = win_idx;
                    gnt_d   = win_oh;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    rsp_det_d = eng_det;
                    rsp_id_d  = sel_q;
`ifdef TDS_TIMEOUT_EN
                    rsp_err_d = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_det_d = '0;
                    rsp_id_d  = sel_q;
                    rsp_err_d = 1'b1;
                    state_d   = S_TOUT;
`endif
                end
                if (eng_done) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: state_d = S_DRAIN;
            S_DRAIN: begin
                // Engine must drop done before the next job can start.
                if (!eng_done) begin
                    rr_ptr_d = sel_next;
                    state_d  = S_IDLE;
                end
            end
`ifdef TDS_TIMEOUT_EN
            S_TOUT: begin
                if (cnt_q == CW'(TOUT_CYCLES - 1)) begin
                    rr_ptr_d = sel_next;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef TDS_TIMEOUT_EN
        cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            rsp_id_q  <= '0;
            rsp_det_q <= '0;
            gnt_q     <= '0;
`ifdef TDS_TIMEOUT_EN
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_id_q  <= rsp_id_d;
            rsp_det_q <= rsp_det_d;
            gnt_q     <= gnt_d;
`ifdef TDS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign eng_start = (state_q == S_START);
    assign eng_ack   = (state_q == S_ACK);
    assign busy      = (state_q != S_IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_det   = rsp_det_q;
    assign state_dbg = state_q;

`ifdef TDS_TIMEOUT_EN
    assign rsp_valid = eng_ack | ((state_q == S_TOUT) && (cnt_q == '0));
    assign eng_rst   = (state_q == S_TOUT);
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_valid = eng_ack;
    assign eng_rst   = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Coefficients are forced to zero while idle so nothing leaks out under reset.
    assign eng_a = busy ? a_in[int'(sel_q)*AW +: AW] : '0;
    assign eng_b = busy ? b_in[int'(sel_q)*BW +: BW] : '0;
    assign eng_c = busy ? c_in[int'(sel_q)*AW +: AW] : '0;

endmodule

// File: tb/tb_tridiag_det_sched.sv
// Directed bench for tridiag_det_sched with a behavioural tridiagonal-determinant engine.
// Build with TDS_TIMEOUT_EN to also exercise the timeout abort path.
module tb_tridiag_det_sched;
    import tridiag_det_pkg::*;

    localparam int NREQ = 4;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int TOUT = 8;
    localparam int AW   = W * (N - 1);
    localparam int BW   = W * N;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*AW-1:0]   a_in = '0;
    logic [NREQ*BW-1:0]   b_in = '0;
    logic [NREQ*AW-1:0]   c_in = '0;
    logic [NREQ-1:0]      gnt;
    logic                 rsp_valid, rsp_err, busy, eng_start, eng_ack, eng_rst;
    logic [1:0]           rsp_id;
    logic [2*W-1:0]       rsp_det;
    logic                 eng_done;
    logic [2*W-1:0]       eng_det;
    logic [AW-1:0]        eng_a, eng_c;
    logic [BW-1:0]        eng_b;
    state_t               state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    bit overlap_seen = 1'b0;
    bit eng_mute = 1'b0;

    always #5 clk = ~clk;

    tridiag_det_sched #(.NREQ(NREQ), .N(N), .WIDTH(W), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_det(rsp_det), .rsp_err(rsp_err),
        .busy(busy), .eng_start(eng_start), .eng_ack(eng_ack),
        .eng_done(eng_done), .eng_det(eng_det),
        .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c),
        .eng_rst(eng_rst), .state_dbg(state_dbg)
    );

    // Continuant recurrence f_k = b_{k-1} f_{k-1} - a_{k-2} c_{k-2} f_{k-2}.
    function automatic logic [2*W-1:0] model_det(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                                 input logic [AW-1:0] c);
        longint fp2, fp1, f, bk, ak, ck;
        fp2 = 1;
        fp1 = longint'($signed(b[W-1:0]));
        for (int k = 2; k <= N; k++) begin
            bk  = longint'($signed(b[(k-1)*W +: W]));
            ak  = longint'($signed(a[(k-2)*W +: W]));
            ck  = longint'($signed(c[(k-2)*W +: W]));
            f   = bk * fp1 - ak * ck * fp2;
            fp2 = fp1;
            fp1 = f;
        end
        return fp1[2*W-1:0];
    endfunction

    logic           eng_running;
    int             eng_cnt;
    logic [2*W-1:0] eng_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || eng_rst) begin
            eng_done <= 1'b0; eng_det <= '0; eng_running <= 1'b0; eng_cnt <= 0; eng_res <= '0;
        end else begin
            if (eng_start) begin
                eng_running <= 1'b1;
                eng_cnt     <= N - 2;
                eng_res     <= model_det(eng_a, eng_b, eng_c);
            end else if (eng_running) begin
                if (eng_cnt > 1) eng_cnt <= eng_cnt - 1;
                else if (!eng_mute) begin
                    eng_done <= 1'b1; eng_det <= eng_res; eng_running <= 1'b0;
                end
            end
            if (eng_done && eng_ack) eng_done <= 1'b0;
        end
    end

    always @(negedge clk) if (rsp_valid && (gnt != '0)) overlap_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_slice(input int k, input shortint b0, b1, b2, b3,
                             input shortint a0, a1, a2, input shortint c0, c1, c2);
        b_in[k*BW +: BW] = {b3, b2, b1, b0};
        a_in[k*AW +: AW] = {a2, a1, a0};
        c_in[k*AW +: AW] = {c2, c1, c0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_gnt(output int idx, output logic [NREQ-1:0] g, output bit ok);
        idx = -1; g = '0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = gnt; ok = 1'b1;
                for (int k = 0; k < NREQ; k++) if (gnt[k]) idx = k;
            end
        end
    endtask

    task automatic wait_rsp(output logic [1:0] id, output logic [2*W-1:0] det,
                            output logic err, output bit ok);
        id = '0; det = '0; err = 1'b0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                id = rsp_id; det = rsp_det; err = rsp_err; ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({gnt, rsp_valid, busy, eng_start, eng_ack, eng_rst, rsp_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctl: got gnt=%b rv=%b busy=%b st=%b ack=%b rst=%b err=%b, want all 0",
                     gnt, rsp_valid, busy, eng_start, eng_ack, eng_rst, rsp_err);
        end
        n_cmp++;
        if (rsp_det !== '0 || rsp_id !== '0 || state_dbg !== S_IDLE) begin
            n_bad++;
            $display("FAIL reset_data: got det=%h id=%0d state=%0d, want 0/0/IDLE", rsp_det, rsp_id, state_dbg);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int idx; logic [NREQ-1:0] g; bit ok; logic [1:0] id; logic [2*W-1:0] det; logic err;
        set_slice(0, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1);
        req = 4'b0001;
        wait_gnt(idx, g, ok);
        n_cmp++;
        if (!ok || g !== 4'b0001 || eng_start !== 1'b1) begin
            n_bad++; $display("FAIL single_gnt: got gnt=%b start=%b ok=%0d, want 0001/1", g, eng_start, ok);
        end
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0 || eng_start !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL single_pulse: got gnt=%b start=%b busy=%b, want 0/0/1", gnt, eng_start, busy);
        end
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || id !== 2'd0 || det !== 32'd5 || err !== 1'b0) begin
            n_bad++; $display("FAIL single_rsp: got ok=%0d id=%0d det=%0d err=%b, want id=0 det=5 err=0",
                              ok, id, $signed(det), err);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL single_busy: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_all_four();
        int idx; logic [NREQ-1:0] g; bit ok; logic [1:0] id; logic [2*W-1:0] det; logic err;
        logic [2*W-1:0] exp_det [NREQ];
        exp_det = '{32'd5, 32'd55, 32'd209, 32'd551};
        for (int k = 0; k < NREQ; k++)
            set_slice(k, shortint'(k+2), shortint'(k+2), shortint'(k+2), shortint'(k+2), 1, 1, 1, 1, 1, 1);
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            wait_gnt(idx, g, ok);
            n_cmp++;
            if (!ok || idx != k) begin
                n_bad++; $display("FAIL rr_gnt%0d: got gnt=%b, want index %0d", k, g, k);
            end
            wait_rsp(id, det, err, ok);
            n_cmp++;
            if (!ok || id !== 2'(k) || det !== exp_det[k]) begin
                n_bad++; $display("FAIL rr_rsp%0d: got id=%0d det=%0d, want id=%0d det=%0d",
                                  k, id, $signed(det), k, $signed(exp_det[k]));
            end
            @(negedge clk);
            req[k] = 1'b0;
        end
    endtask

    task automatic test_fairness();
        int idx; logic [NREQ-1:0] g; bit ok; logic [1:0] id; logic [2*W-1:0] det; logic err;
        req = 4'b0001;
        wait_gnt(idx, g, ok);
        req[2] = 1'b1;
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || id !== 2'd0 || det !== 32'd5) begin
            n_bad++; $display("FAIL fair_first: got id=%0d det=%0d, want 0/5", id, $signed(det));
        end
        wait_gnt(idx, g, ok);
        n_cmp++;
        if (!ok || idx != 2) begin
            n_bad++; $display("FAIL fair_next: got gnt=%b, want 0100", g);
        end
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || id !== 2'd2 || det !== 32'd209) begin
            n_bad++; $display("FAIL fair_rsp2: got id=%0d det=%0d, want 2/209", id, $signed(det));
        end
        @(negedge clk);
        req[2] = 1'b0;
        wait_gnt(idx, g, ok);
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || idx != 0 || id !== 2'd0) begin
            n_bad++; $display("FAIL fair_back0: got gnt_idx=%0d id=%0d, want 0/0", idx, id);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_negative();
        int idx; logic [NREQ-1:0] g; bit ok; logic [1:0] id; logic [2*W-1:0] det; logic err;
        set_slice(1, -3, 4, -1, 2, 1, -2, 1, 2, 1, -1);
        set_slice(3, -1, -1, -1, -1, 1, 1, 1, 1, 1, 1);
        req = 4'b1010;
        wait_gnt(idx, g, ok);
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || idx != 1 || id !== 2'd1 || det !== 32'sd2) begin
            n_bad++; $display("FAIL neg_mixed: got gnt_idx=%0d id=%0d det=%0d, want 1/1/2", idx, id, $signed(det));
        end
        @(negedge clk);
        req[1] = 1'b0;
        wait_gnt(idx, g, ok);
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || idx != 3 || id !== 2'd3 || det !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL neg_minus1: got gnt_idx=%0d id=%0d det=%0d, want 3/3/-1", idx, id, $signed(det));
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_reset_mid_job();
        int idx; logic [NREQ-1:0] g; bit ok; logic [1:0] id; logic [2*W-1:0] det; logic err;
        req = 4'b0100;
        wait_gnt(idx, g, ok);
        wait_rsp(id, det, err, ok);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        req = 4'b0100;
        wait_gnt(idx, g, ok);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, rsp_valid, busy, eng_start, eng_ack, eng_rst, rsp_err} !== '0 || state_dbg !== S_IDLE) begin
            n_bad++; $display("FAIL async_ctl: got gnt=%b rv=%b busy=%b st=%b ack=%b state=%0d, want 0/IDLE",
                              gnt, rsp_valid, busy, eng_start, eng_ack, state_dbg);
        end
        n_cmp++;
        if (rsp_det !== '0 || rsp_id !== '0 || eng_a !== '0 || eng_b !== '0 || eng_c !== '0) begin
            n_bad++; $display("FAIL async_data: got det=%h id=%0d a=%h b=%h c=%h, want 0",
                              rsp_det, rsp_id, eng_a, eng_b, eng_c);
        end
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(idx, g, ok);
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || idx != 0 || id !== 2'd0 || det !== 32'd5) begin
            n_bad++; $display("FAIL post_reset: got gnt_idx=%0d id=%0d det=%0d, want 0/0/5", idx, id, $signed(det));
        end
        @(negedge clk);
        req[0] = 1'b0;
        wait_gnt(idx, g, ok);
        wait_rsp(id, det, err, ok);
        @(negedge clk);
        req = '0;
    endtask

`ifdef TDS_TIMEOUT_EN
    task automatic test_timeout();
        int idx; logic [NREQ-1:0] g; bit ok; logic [1:0] id; logic [2*W-1:0] det; logic err;
        bit early;
        eng_mute = 1'b1;
        req = 4'b0010;
        wait_gnt(idx, g, ok);
        early = 1'b0;
        for (int i = 0; i < TOUT; i++) begin
            @(negedge clk);
            if (eng_rst || rsp_valid) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++; $display("FAIL tout_early: got early eng_rst/rsp=%b, want 0", early);
        end
        @(negedge clk);
        n_cmp++;
        if (eng_rst !== 1'b1 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_det !== '0 || rsp_id !== 2'd1) begin
            n_bad++; $display("FAIL tout_rsp: got rst=%b rv=%b err=%b det=%h id=%0d, want 1/1/1/0/1",
                              eng_rst, rsp_valid, rsp_err, rsp_det, rsp_id);
        end
        @(negedge clk);
        req = '0;
        n_cmp++;
        if (eng_rst !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL tout_rst2: got rst=%b rv=%b, want 1/0", eng_rst, rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (eng_rst !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL tout_end: got rst=%b busy=%b, want 0/0", eng_rst, busy);
        end
        eng_mute = 1'b0;
        req = 4'b0101;
        wait_gnt(idx, g, ok);
        wait_rsp(id, det, err, ok);
        n_cmp++;
        if (!ok || idx != 2 || id !== 2'd2 || det !== 32'd209 || err !== 1'b0) begin
            n_bad++; $display("FAIL tout_next: got gnt_idx=%0d id=%0d det=%0d err=%b, want 2/2/209/0",
                              idx, id, $signed(det), err);
        end
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
    endtask
`endif

    task automatic test_invariants();
        n_cmp++;
        if (overlap_seen !== 1'b0) begin
            n_bad++; $display("FAIL gnt_rsp_overlap: got overlap=%b, want 0", overlap_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_negative();
        test_reset_mid_job();
`ifdef TDS_TIMEOUT_EN
        test_timeout();
`endif
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
